// File: rtl/mdu_div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divider controller: state encoding,
// req_op bit positions, iteration count and divide-by-zero constants.
package mdu_div_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Bit positions inside req_op, same ordering as the decode-stage mul_div_op.
  localparam int OP_DIV_W  = 3;
  localparam int OP_MOD_W  = 2;
  localparam int OP_DIV_WU = 1;
  localparam int OP_MOD_WU = 0;

  localparam int          DIV_ITER    = 32;
  localparam logic [31:0] DZ_QUOTIENT = 32'hFFFF_FFFF;

  function automatic logic is_onehot4(input logic [3:0] op);
    return (op != 4'd0) && ((op & (op - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/mdu_div_ctrl_div_step.sv
// One restoring radix-2 divide step on a {remainder, quotient} pair.
module div_step (
  input  logic [63:0] rem_quo_i,
  input  logic [31:0] divisor_i,
  output logic [63:0] rem_quo_o
);

  logic [32:0] partial;
  logic [32:0] diff;
  logic        q_bit;

  // The partial remainder stays below twice the divisor, so bit 32 of the
  // 33-bit difference is an exact borrow.
  assign partial = rem_quo_i[63:31];
  assign diff    = partial - {1'b0, divisor_i};
  assign q_bit   = ~diff[32];

  assign rem_quo_o = q_bit ? {diff[31:0], rem_quo_i[30:0], 1'b1}
                           : {rem_quo_i[62:0], 1'b0};

endmodule

// File: rtl/mdu_div_ctrl.sv
// 32-bit signed/unsigned divide controller: accept, prepare, 32 restoring
// steps, then hold the result until the EXE stage takes it.
module mdu_div_ctrl
  import mdu_div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic [4:0]  req_dest,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_dest,
  output logic        busy
);

  div_state_e  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] abs1_q, abs1_d;
  logic [31:0] abs2_q, abs2_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        dz_q, dz_d;
  logic [63:0] rq_q, rq_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        accept;
  logic        signed_op;
  logic [63:0] step_rq;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  div_step u_step (
    .rem_quo_i (rq_q),
    .divisor_i (abs2_q),
    .rem_quo_o (step_rq)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign accept     = req_valid && req_ready && !flush && is_onehot4(req_op);
  assign signed_op  = req_op[OP_DIV_W] | req_op[OP_MOD_W];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dest_d  = dest_q;
    abs1_d  = abs1_q;
    abs2_d  = abs2_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dz_d    = dz_q;
    rq_d    = rq_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = req_op;
          dest_d  = req_dest;
          s1_d    = signed_op & req_src1[31];
          s2_d    = signed_op & req_src2[31];
          abs1_d  = (signed_op & req_src1[31]) ? -req_src1 : req_src1;
          abs2_d  = (signed_op & req_src2[31]) ? -req_src2 : req_src2;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        cnt_d = 5'd0;
        // Divide by zero skips the iterations; the remainder half carries
        // |dividend| so the normal sign fix-up restores the original dividend.
        if (abs2_q == 32'd0) begin
          rq_d    = {abs1_q, DZ_QUOTIENT};
          dz_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          rq_d    = {32'd0, abs1_q};
          dz_d    = 1'b0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        rq_d  = step_rq;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITER - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      op_q    <= 4'd0;
      dest_q  <= 5'd0;
      abs1_q  <= 32'd0;
      abs2_q  <= 32'd0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      dz_q    <= 1'b0;
      rq_q    <= 64'd0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      abs1_q  <= abs1_d;
      abs2_q  <= abs2_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dz_q    <= dz_d;
      rq_q    <= rq_d;
      cnt_q   <= cnt_d;
    end
  end

  // The all-ones divide-by-zero quotient is never negated.
  assign q_fix = (!dz_q && (s1_q ^ s2_q)) ? -rq_q[31:0] : rq_q[31:0];
  assign r_fix = s1_q ? -rq_q[63:32] : rq_q[63:32];

  assign resp_result = (op_q[OP_DIV_W] | op_q[OP_DIV_WU]) ? q_fix : r_fix;
  assign resp_dest   = dest_q;

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Directed bench for mdu_div_ctrl: vector table plus flush, reset and
// back-pressure sequences.
module tb_mdu_div_ctrl;

  localparam logic [3:0] DIV_W  = 4'b1000;
  localparam logic [3:0] MOD_W  = 4'b0100;
  localparam logic [3:0] DIV_WU = 4'b0010;
  localparam logic [3:0] MOD_WU = 4'b0001;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [4:0]  req_dest;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic [4:0]  resp_dest;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vq[$];

  mdu_div_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .req_dest    (req_dest),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_dest   (resp_dest),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp,
                         input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.dest = d; v.exp = exp; v.lat = lat;
    vq.push_back(v);
  endtask

  // Called at a negedge while idle; returns at the negedge of cycle t+1.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d);
    chk("req_ready_at_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_dest  = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 4'd0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 80) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic watch_no_resp(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    int lat;

    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_op     = 4'd0;
    req_src1   = 32'd0;
    req_src2   = 32'd0;
    req_dest   = 5'd0;
    flush      = 1'b0;
    resp_ready = 1'b1;

    add_vec("div_w_7_2",        DIV_W,  32'd7,         32'd2,         5'd9,  32'h0000_0003, 34);
    add_vec("mod_w_m7_2",       MOD_W,  32'hFFFF_FFF9, 32'd2,         5'd1,  32'hFFFF_FFFF, 34);
    add_vec("mod_wu_m7_2",      MOD_WU, 32'hFFFF_FFF9, 32'd2,         5'd2,  32'h0000_0001, 34);
    add_vec("div_w_ovf",        DIV_W,  32'h8000_0000, 32'hFFFF_FFFF, 5'd3,  32'h8000_0000, 34);
    add_vec("mod_w_ovf",        MOD_W,  32'h8000_0000, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000, 34);
    add_vec("div_wu_dz",        DIV_WU, 32'h1234_5678, 32'd0,         5'd5,  32'hFFFF_FFFF, 2);
    add_vec("mod_wu_dz",        MOD_WU, 32'h1234_5678, 32'd0,         5'd6,  32'h1234_5678, 2);
    add_vec("div_w_dz_neg",     DIV_W,  32'hFFFF_FFF9, 32'd0,         5'd7,  32'hFFFF_FFFF, 2);
    add_vec("mod_w_dz_neg",     MOD_W,  32'hFFFF_FFF9, 32'd0,         5'd8,  32'hFFFF_FFF9, 2);
    add_vec("div_w_m100_7",     DIV_W,  32'hFFFF_FF9C, 32'd7,         5'd10, 32'hFFFF_FFF2, 34);
    add_vec("mod_w_m100_7",     MOD_W,  32'hFFFF_FF9C, 32'd7,         5'd11, 32'hFFFF_FFFE, 34);
    add_vec("div_w_100_m7",     DIV_W,  32'd100,       32'hFFFF_FFF9, 5'd12, 32'hFFFF_FFF2, 34);
    add_vec("mod_w_100_m7",     MOD_W,  32'd100,       32'hFFFF_FFF9, 5'd13, 32'h0000_0002, 34);
    add_vec("div_wu_big",       DIV_WU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd14, 32'h0000_0001, 34);
    add_vec("mod_wu_big",       MOD_WU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd15, 32'h7FFF_FFFF, 34);
    add_vec("div_wu_by1",       DIV_WU, 32'hFFFF_FFFF, 32'd1,         5'd16, 32'hFFFF_FFFF, 34);
    add_vec("mod_wu_deadbeef",  MOD_WU, 32'hDEAD_BEEF, 32'h10,        5'd31, 32'h0000_000F, 34);

    repeat (2) @(negedge clk);
    resetn = 1'b1;
    chk("reset_req_ready",   {31'd0, req_ready},  32'd1);
    chk("reset_busy",        {31'd0, busy},       32'd0);
    chk("reset_resp_valid",  {31'd0, resp_valid}, 32'd0);
    chk("reset_resp_result", resp_result,         32'd0);
    chk("reset_resp_dest",   {27'd0, resp_dest},  32'd0);

    foreach (vq[i]) begin
      issue(vq[i].op, vq[i].a, vq[i].b, vq[i].dest);
      wait_resp(lat);
      chk({vq[i].name, "_latency"}, lat, vq[i].lat);
      chk({vq[i].name, "_result"}, resp_result, vq[i].exp);
      chk({vq[i].name, "_dest"}, {27'd0, resp_dest}, {27'd0, vq[i].dest});
      $display("txn %s op=%b a=%h b=%h result=%h dest=%0d latency=%0d",
               vq[i].name, vq[i].op, vq[i].a, vq[i].b, resp_result, resp_dest, lat);
      @(negedge clk);
      chk({vq[i].name, "_idle_after"}, {31'd0, req_ready}, 32'd1);
    end

    // Flush in the 10th CALC cycle (accept t, PREP t+1, CALC from t+2).
    issue(DIV_WU, 32'd100, 32'd7, 5'd3);
    repeat (10) @(negedge clk);
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle_ready", {31'd0, req_ready},  32'd1);
    chk("flush_idle_busy",  {31'd0, busy},       32'd0);
    chk("flush_no_valid",   {31'd0, resp_valid}, 32'd0);
    watch_no_resp("flush_no_resp_later", 40);
    $display("txn flush_mid_calc discarded");
    issue(DIV_WU, 32'd100, 32'd7, 5'd20);
    wait_resp(lat);
    chk("post_flush_latency", lat, 34);
    chk("post_flush_result", resp_result, 32'h0000_000E);
    chk("post_flush_dest", {27'd0, resp_dest}, 32'd20);
    $display("txn post_flush div_wu 100/7 result=%h latency=%0d", resp_result, lat);
    @(negedge clk);

    // Back-pressure: resp_ready low for several DONE cycles.
    resp_ready = 1'b0;
    issue(MOD_WU, 32'd100, 32'd7, 5'd21);
    wait_resp(lat);
    chk("hold_latency", lat, 34);
    chk("hold_result_first", resp_result, 32'h0000_0002);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_result", resp_result, 32'h0000_0002);
      chk("hold_dest", {27'd0, resp_dest}, 32'd21);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_ready", {31'd0, req_ready},  32'd1);
    chk("hold_release_valid", {31'd0, resp_valid}, 32'd0);
    $display("txn hold mod_wu 100/7 result=2 released");

    // Flush while sitting in DONE discards the pending result.
    resp_ready = 1'b0;
    issue(DIV_WU, 32'd9, 32'd0, 5'd22);
    wait_resp(lat);
    chk("flush_done_latency", lat, 2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    resp_ready = 1'b1;
    chk("flush_done_valid", {31'd0, resp_valid}, 32'd0);
    chk("flush_done_ready", {31'd0, req_ready},  32'd1);
    $display("txn flush_in_done discarded");

    // Flush wins over a simultaneous request; non-one-hot ops are ignored.
    req_valid = 1'b1; req_op = DIV_WU; req_src1 = 32'd10; req_src2 = 32'd2; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_accept_busy", {31'd0, busy}, 32'd0);
    req_valid = 1'b1; req_op = 4'b0011;
    @(negedge clk);
    chk("non_onehot_busy", {31'd0, busy}, 32'd0);
    req_op = 4'b0000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("zero_op_busy", {31'd0, busy}, 32'd0);
    watch_no_resp("ignored_req_no_resp", 40);
    $display("txn ignored_requests none accepted");

    // Reset in the middle of CALC aborts with no response.
    issue(DIV_W, 32'd7, 32'd2, 5'd23);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("midreset_busy",   {31'd0, busy},       32'd0);
    chk("midreset_valid",  {31'd0, resp_valid}, 32'd0);
    chk("midreset_result", resp_result,         32'd0);
    chk("midreset_dest",   {27'd0, resp_dest},  32'd0);
    watch_no_resp("midreset_no_resp", 40);
    $display("txn reset_mid_calc aborted");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_div_ctrl.md
MDU_DIV_CTRL -- requirements
Module: mdu_div_ctrl

Interface
REQ-001 SHALL have clk, input, 1, clock; all state updates on posedge clk.
REQ-002 SHALL have resetn, input, 1, synchronous active-low reset.
REQ-003 SHALL have req_valid, input, 1, EXE holds a valid divide instruction.
REQ-004 SHALL have req_ready, output, 1, controller can accept; high only in IDLE.
REQ-005 SHALL have req_op, input, 4, one-hot {div_w, mod_w, div_wu, mod_wu}.
REQ-006 SHALL have req_src1 / req_src2, input, 32 each, dividend / divisor.
REQ-007 SHALL have req_dest, input, 5, destination register tag.
REQ-008 SHALL have flush, input, 1, pipeline cancel; aborts any operation.
REQ-009 SHALL have resp_valid, output, 1, result available (EXE ready_go).
REQ-010 SHALL have resp_ready, input, 1, EXE allowed to pass result to MEM.
REQ-011 SHALL have resp_result, output, 32, quotient or remainder per op.
REQ-012 SHALL have resp_dest, output, 5, latched req_dest.
REQ-013 SHALL have busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> PREP -> CALC -> DONE -> IDLE.
REQ-015 SHALL accept a request when req_valid && req_ready && !flush; it latches op, dest, |src1|, |src2| and the sign flags, then enters PREP.
REQ-016 PREP SHALL last 1 cycle and clear the remainder/quotient registers and iteration counter; if divisor==0 go to DONE, else go to CALC.
REQ-017 CALC SHALL perform one restoring radix-2 step per cycle for exactly 32 cycles, with a 5-bit counter running 0..31; at 31, go to DONE.
REQ-018 Latency SHALL be: accept in cycle t -> resp_valid first high in cycle t+34; divide by zero -> cycle t+2.
REQ-019 DONE SHALL hold resp_valid=1 with stable resp_result/resp_dest until resp_valid && resp_ready, then go to IDLE; no accept is possible in the same cycle.
REQ-020 Signed ops SHALL use magnitudes; the quotient is negated iff the operand signs differ; the remainder takes the sign of the dividend.
REQ-021 Overflow 0x80000000 / 0xFFFFFFFF (signed) SHALL yield quotient 0x80000000, remainder 0.
REQ-022 Divisor 0 SHALL yield quotient 0xFFFFFFFF and remainder = dividend, for all ops.
REQ-023 resp_result SHALL select the quotient for div_w/div_wu and the remainder for mod_w/mod_wu.
REQ-024 flush SHALL force IDLE at the next edge from any state, discarding results; resp_valid is low the following cycle.
REQ-025 flush SHALL have priority over a simultaneous accept and over a simultaneous resp handshake.
REQ-026 req_op not one-hot SHALL be treated as no request (no accept).

Reset
REQ-027 On resetn=0 at posedge: state=IDLE, counter=0, data registers=0, resp_valid=0, resp_result=0, resp_dest=0, busy=0, req_ready=1 on the first cycle after reset.
REQ-028 Reset mid-CALC or mid-DONE SHALL abort with no response issued.

Structure
REQ-029 The shared header SHALL define the state encoding, the req_op bit positions matching the decode-stage mul_div_op ordering, DIV_ITER=32 and the divide-by-zero constants.
REQ-030 The restoring step (64-bit partial remainder shift, 33-bit subtract, quotient bit) SHALL be a separate combinational sub-module, div_step; the FSM, counter, sign fix-up and handshake stay in mdu_div_ctrl.

Verification
REQ-031 div_w 7/2, resp_ready=1 -> resp_valid at t+34, result 0x00000003, resp_dest echoed.
REQ-032 mod_w 0xFFFFFFF9 (-7) by 2 -> 0xFFFFFFFF; mod_wu same operands -> 0x00000001.
REQ-033 div_w 0x80000000 by 0xFFFFFFFF -> 0x80000000; mod_w -> 0x00000000.
REQ-034 div_wu 0x12345678 by 0 -> resp_valid at t+2, result 0xFFFFFFFF; mod_wu -> 0x12345678.
REQ-035 flush in the 10th CALC cycle -> IDLE next cycle, no resp_valid; a new div_wu 100/7 then returns 0x0000000E at its own t+34.
REQ-036 resp_ready held low 5 cycles in DONE -> resp_valid and resp_result stable throughout, req_ready low; IDLE in the cycle after resp_ready rises.
